// File: rtl/dbus_sram_slave_if.sv
// Initiator/target bus bundle for the SRAM slave.
// O_dbus_err is present only when DBUS_SRAM_ERR_EN is defined.
interface dbus_sram_slave_if;
    logic        I_dbus_req;
    logic        I_dbus_we;
    logic [31:0] I_dbus_addr;
    logic [31:0] I_dbus_data;
    logic [3:0]  I_dbus_mask;
    logic [31:0] O_dbus_data;
    logic        O_dbus_ready;
`ifdef DBUS_SRAM_ERR_EN
    logic        O_dbus_err;
`endif

    modport master (
        output I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask,
`ifdef DBUS_SRAM_ERR_EN
        input  O_dbus_err,
`endif
        input  O_dbus_data, O_dbus_ready
    );

    modport slave (
        input  I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask,
`ifdef DBUS_SRAM_ERR_EN
        output O_dbus_err,
`endif
        output O_dbus_data, O_dbus_ready
    );
endinterface

// File: rtl/dbus_sram_slave.sv
// Word-addressed SRAM target with fixed wait states and byte-masked writes.
// Optional out-of-range error flag when DBUS_SRAM_ERR_EN is defined.
module dbus_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    dbus_sram_slave_if.slave bus
);

    localparam int          IDXW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_LD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic [31:0] rdata_q;
    logic        ready_q;
`ifdef DBUS_SRAM_ERR_EN
    logic        err_q;
`endif

    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the commit edge is also the sampling edge, so
    // the live inputs stand in for the not-yet-latched fields.
    logic            in_idle;
    logic            enter_resp;
    logic            c_we;
    logic [31:0]     c_addr;
    logic [31:0]     c_data;
    logic [3:0]      c_mask;
    logic            in_range;
    logic [IDXW-1:0] idx;

    always_comb begin
        in_idle    = (state_q == IDLE);
        enter_resp = (in_idle && bus.I_dbus_req && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd0));
        c_we       = in_idle ? bus.I_dbus_we   : we_q;
        c_addr     = in_idle ? bus.I_dbus_addr : addr_q;
        c_data     = in_idle ? bus.I_dbus_data : wdata_q;
        c_mask     = in_idle ? bus.I_dbus_mask : mask_q;
        in_range   = ({1'b0, c_addr[31:2], 2'b00} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, c_addr[31:2], 2'b00} <  END_ADDR);
        idx        = IDXW'((c_addr - BASE_ADDR) >> 2);
    end

    // Array has no reset so contents survive rst; gating on rst drops a
    // commit that would coincide with reset being held.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && c_we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (c_mask[b]) mem[idx][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
`ifdef DBUS_SRAM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            // Outputs are registered from the transition into RESP so they
            // are high for exactly the RESP cycle and zero elsewhere.
            ready_q <= enter_resp;
            rdata_q <= (enter_resp && !c_we && in_range) ? mem[idx] : 32'h0;
`ifdef DBUS_SRAM_ERR_EN
            err_q   <= enter_resp && !in_range;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.I_dbus_req) begin
                        we_q    <= bus.I_dbus_we;
                        addr_q  <= bus.I_dbus_addr;
                        wdata_q <= bus.I_dbus_data;
                        mask_q  <= bus.I_dbus_mask;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_LD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.O_dbus_data  = rdata_q;
    assign bus.O_dbus_ready = ready_q;
`ifdef DBUS_SRAM_ERR_EN
    assign bus.O_dbus_err   = err_q;
`endif

endmodule

// File: doc/dbus_sram_slave.md
DBUS_SRAM_SLAVE -- requirements
Module: dbus_sram_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, default 4096: number of 32-bit words in the array.
REQ-003 Parameter WAIT_CYCLES, default 1, range 0..15: extra wait states per transaction.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 I_dbus_req  input  1  initiator request; held high until O_dbus_ready.
REQ-007 I_dbus_we  input  1  1 = write, 0 = read.
REQ-008 I_dbus_addr  input  32  byte address; bits [1:0] are ignored.
REQ-009 I_dbus_data  input  32  write data.
REQ-010 I_dbus_mask  input  4  byte enables; bit i enables data[8i+7:8i].
REQ-011 O_dbus_data  output  32  read data; valid only while O_dbus_ready=1 on a read.
REQ-012 O_dbus_ready  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with I_dbus_req=1, the rising edge SHALL latch we, addr, data and mask, then move to WAIT (WAIT_CYCLES>0) or to RESP (WAIT_CYCLES=0).
REQ-015 On entering WAIT, a 4-bit counter SHALL load WAIT_CYCLES-1.
REQ-016 In WAIT, the counter SHALL decrement each cycle; the FSM moves to RESP on the edge where the counter is 0.
REQ-017 RESP SHALL last exactly one cycle with O_dbus_ready=1, then return to IDLE unconditionally.
REQ-018 Latency: O_dbus_ready SHALL be high in the cycle starting WAIT_CYCLES+1 edges after the request-sampling edge.
REQ-019 Throughput SHALL be one transaction per WAIT_CYCLES+2 cycles; a request still high in the cycle after RESP is a new transaction.
REQ-020 Latched fields SHALL be used for the whole transaction; input changes, including req deassertion, after latching SHALL be ignored and the transaction SHALL complete.
REQ-021 Index = (addr - BASE_ADDR) >> 2; an address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
REQ-022 For an in-range write, only mask-enabled bytes SHALL be updated, on the edge that enters RESP.
REQ-023 For an in-range read, the word SHALL be registered into O_dbus_data on the edge that enters RESP.
REQ-024 An out-of-range write SHALL modify nothing; an out-of-range read SHALL return 32'h0; O_dbus_ready SHALL still pulse.
REQ-025 A write with mask 4'b0000 SHALL change no memory and SHALL still complete normally.
REQ-026 O_dbus_data SHALL be 32'h0 in every cycle that is not a read RESP cycle.

Reset
REQ-027 rst low SHALL force IDLE, counter to 0, O_dbus_ready=0, O_dbus_data=0 and latched fields to 0, immediately and without a clock.
REQ-028 Reset asserted during WAIT or RESP SHALL abort the transaction; a write not yet committed SHALL be dropped, and no ready SHALL be issued for it.
REQ-029 The memory array SHALL NOT be reset; its contents SHALL persist across reset.
REQ-030 The first request SHALL be sampled on the first rising edge after rst deasserts.

Configuration
REQ-031 With macro DBUS_SRAM_ERR_EN defined, the block SHALL add output O_dbus_err (1 bit) that is 1 only in a RESP cycle whose latched address is out of range, and 0 otherwise, including 0 at reset.
REQ-032 Without DBUS_SRAM_ERR_EN, O_dbus_err SHALL NOT exist, and out-of-range behaviour SHALL be as in REQ-024.

Verification
REQ-033 WAIT_CYCLES=1: write 0xDEADBEEF, mask 4'hF, to 0x8000_0010 -> ready 2 cycles after the sampling edge; a read of 0x8000_0010 returns 0xDEADBEEF with ready.
REQ-034 Partial write: preload 0x11223344, write 0xAABBCCDD with mask 4'b0101 -> a read returns 0x11BB33DD.
REQ-035 WAIT_CYCLES=0: back-to-back reads with req held high -> ready pulses every 2nd cycle; O_dbus_data is 0 between pulses.
REQ-036 Out of range: read 0x7FFF_FFFC -> data 0 with ready; with DBUS_SRAM_ERR_EN, O_dbus_err=1 in the same cycle only.
REQ-037 Reset mid-WAIT, WAIT_CYCLES=3: pull rst low during a write to 0x8000_0000 -> no ready; a later read returns the old value; other prior contents are intact.
REQ-038 Input change after latch: a read is latched at 0x8000_0004, then addr changes to 0x8000_0008 during WAIT -> the data of 0x8000_0004 is returned.
